// File: rtl/pipe_reg_chain_if.sv
// pipe_reg_chain_if -- bundle for the pipe_reg_chain register chain.
//   en         : advance enable (1 = shift, 0 = stall)
//   flush      : synchronous kill of every in-flight entry
//   in_valid/d : stage-0 input entry
//   q/out_valid: oldest stage (DEPTH-1) data and valid
//   valid_vec  : valid bits of all stages, bit i = stage i
//   count      : number of valid stages
// master = the producer/consumer around the chain, slave = the chain.
interface pipe_reg_chain_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    logic             en;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             out_valid;
    logic [DEPTH-1:0] valid_vec;
    logic [3:0]       count;

    modport master (
        output en, flush, in_valid, d,
        input  q, out_valid, valid_vec, count
    );

    modport slave (
        input  en, flush, in_valid, d,
        output q, out_valid, valid_vec, count
    );
endinterface

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain -- DEPTH-stage register chain with per-stage valid bits,
// stall (en=0) and synchronous flush.
//   clk : rising-edge clock
//   clr : asynchronous active-high reset (data <- RST_VAL, valid <- 0)
//   bus : pipe_reg_chain_if.slave (en, flush, in_valid, d in;
//         q, out_valid, valid_vec, count out)
// WIDTH/DEPTH of the connected interface must match this module's.
// Priority per edge: clr > flush > en > hold.

// One stage: data + valid register pair.
module pipe_reg_stage #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    parameter bit               FLUSH_DATA = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             flush,
    input  logic             vin,
    input  logic [WIDTH-1:0] din,
    output logic             vout,
    output logic [WIDTH-1:0] dout
);
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            vout <= 1'b0;
            dout <= RST_VAL;
        end else if (flush) begin
            // flush kills the entry; data either holds or is scrubbed
            vout <= 1'b0;
            if (FLUSH_DATA)
                dout <= RST_VAL;
        end else if (en) begin
            // data moves even for invalid entries; the valid bit marks them
            vout <= vin;
            dout <= din;
        end
    end
endmodule

module pipe_reg_chain #(
    parameter int               WIDTH      = 32,
    parameter int               DEPTH      = 2,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    parameter bit               FLUSH_DATA = 1'b0
) (
    input  logic                clk,
    input  logic                clr,
    pipe_reg_chain_if.slave     bus
);
    // index 0 is the chain input, index i+1 is the output of stage i
    logic [DEPTH:0][WIDTH-1:0] dat_pipe;
    logic [DEPTH:0]            vld_pipe;
    logic [3:0]                cnt;

    assign dat_pipe[0] = bus.d;
    assign vld_pipe[0] = bus.in_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stg
        pipe_reg_stage #(
            .WIDTH      (WIDTH),
            .RST_VAL    (RST_VAL),
            .FLUSH_DATA (FLUSH_DATA)
        ) u_stg (
            .clk   (clk),
            .clr   (clr),
            .en    (bus.en),
            .flush (bus.flush),
            .vin   (vld_pipe[i]),
            .din   (dat_pipe[i]),
            .vout  (vld_pipe[i+1]),
            .dout  (dat_pipe[i+1])
        );
    end

    // popcount of the stage valid bits; DEPTH <= 8 fits in 4 bits
    always_comb begin
        cnt = 4'd0;
        for (int i = 1; i <= DEPTH; i++)
            cnt = cnt + {3'b000, vld_pipe[i]};
    end

    assign bus.q         = dat_pipe[DEPTH];
    assign bus.out_valid = vld_pipe[DEPTH];
    assign bus.valid_vec = vld_pipe[DEPTH:1];
    assign bus.count     = cnt;
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain -- four chain configurations driven by one stimulus
// stream: u2 (DEPTH=2), u2f (DEPTH=2, RST_VAL=DEADBEEF, FLUSH_DATA=1),
// u4 (DEPTH=4), u1 (DEPTH=1). Valid entries are pushed into per-DUT queues
// when accepted and popped when they reach q; valid bits are tracked by a
// small shadow model. Directed sequences cover latency, stall, flush,
// bubbles, async reset and the single-stage case.
module tb_pipe_reg_chain;
    localparam int DK[4] = '{2, 2, 4, 1};
    localparam logic [31:0] RV[4] = '{32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0};

    logic        clk;
    logic        clr;
    logic        en, flush, in_valid;
    logic [31:0] d;

    int n_run  = 0;
    int n_fail = 0;

    logic [31:0] sbq [4][$];
    logic [7:0]  vexp [4];

    pipe_reg_chain_if #(.WIDTH(32), .DEPTH(2)) i2  ();
    pipe_reg_chain_if #(.WIDTH(32), .DEPTH(2)) i2f ();
    pipe_reg_chain_if #(.WIDTH(32), .DEPTH(4)) i4  ();
    pipe_reg_chain_if #(.WIDTH(32), .DEPTH(1)) i1  ();

    pipe_reg_chain #(.WIDTH(32), .DEPTH(2), .RST_VAL(32'h0), .FLUSH_DATA(1'b0))
        u2 (.clk(clk), .clr(clr), .bus(i2.slave));
    pipe_reg_chain #(.WIDTH(32), .DEPTH(2), .RST_VAL(32'hDEAD_BEEF), .FLUSH_DATA(1'b1))
        u2f (.clk(clk), .clr(clr), .bus(i2f.slave));
    pipe_reg_chain #(.WIDTH(32), .DEPTH(4), .RST_VAL(32'h0), .FLUSH_DATA(1'b0))
        u4 (.clk(clk), .clr(clr), .bus(i4.slave));
    pipe_reg_chain #(.WIDTH(32), .DEPTH(1), .RST_VAL(32'h0), .FLUSH_DATA(1'b0))
        u1 (.clk(clk), .clr(clr), .bus(i1.slave));

    assign i2.en  = en;  assign i2.flush  = flush; assign i2.in_valid  = in_valid; assign i2.d  = d;
    assign i2f.en = en;  assign i2f.flush = flush; assign i2f.in_valid = in_valid; assign i2f.d = d;
    assign i4.en  = en;  assign i4.flush  = flush; assign i4.in_valid  = in_valid; assign i4.d  = d;
    assign i1.en  = en;  assign i1.flush  = flush; assign i1.in_valid  = in_valid; assign i1.d  = d;

    logic [31:0] qo  [4];
    logic        ovo [4];
    logic [7:0]  vvo [4];
    logic [3:0]  cno [4];

    assign qo[0] = i2.q;  assign ovo[0] = i2.out_valid;  assign vvo[0] = {6'b0, i2.valid_vec};  assign cno[0] = i2.count;
    assign qo[1] = i2f.q; assign ovo[1] = i2f.out_valid; assign vvo[1] = {6'b0, i2f.valid_vec}; assign cno[1] = i2f.count;
    assign qo[2] = i4.q;  assign ovo[2] = i4.out_valid;  assign vvo[2] = {4'b0, i4.valid_vec};  assign cno[2] = i4.count;
    assign qo[3] = i1.q;  assign ovo[3] = i1.out_valid;  assign vvo[3] = {7'b0, i1.valid_vec};  assign cno[3] = i1.count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] vmask(input int k);
        return 8'((1 << DK[k]) - 1);
    endfunction

    function automatic logic [31:0] ones(input logic [7:0] v);
        logic [31:0] n = 0;
        for (int i = 0; i < 8; i++) n = n + 32'(v[i]);
        return n;
    endfunction

    task automatic clear_models();
        for (int k = 0; k < 4; k++) begin
            sbq[k].delete();
            vexp[k] = '0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_q%0d", tag, k), qo[k], RV[k]);
            chk($sformatf("%s_ov%0d", tag, k), 32'(ovo[k]), 32'd0);
            chk($sformatf("%s_vv%0d", tag, k), 32'(vvo[k]), 32'd0);
            chk($sformatf("%s_cnt%0d", tag, k), 32'(cno[k]), 32'd0);
        end
    endtask

    // one clock: record accepted entries, advance, then check every DUT
    task automatic step();
        logic e, f, v;
        logic [31:0] dd;
        e = en; f = flush; v = in_valid; dd = d;
        if (e && !f && v)
            for (int k = 0; k < 4; k++) sbq[k].push_back(dd);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (f) begin
                sbq[k].delete();
                vexp[k] = '0;
            end else if (e) begin
                vexp[k] = ((vexp[k] << 1) | {7'b0, v}) & vmask(k);
                if (ovo[k]) begin
                    chk($sformatf("sb_nonempty%0d", k), 32'(sbq[k].size() != 0), 32'd1);
                    if (sbq[k].size() != 0)
                        chk($sformatf("sb_q%0d", k), qo[k], sbq[k].pop_front());
                end
            end
            chk($sformatf("vv%0d", k), 32'(vvo[k]), 32'(vexp[k]));
            chk($sformatf("ov%0d", k), 32'(ovo[k]), 32'(vexp[k][DK[k]-1]));
            chk($sformatf("cnt%0d", k), 32'(cno[k]), ones(vexp[k]));
        end
        if (f) chk("flush_scrub_u2f", qo[1], 32'hDEAD_BEEF);
    endtask

    task automatic drive(input logic e, input logic f, input logic v, input logic [31:0] dv);
        en = e; flush = f; in_valid = v; d = dv;
    endtask

    initial begin
        clr = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        clear_models();

        // reset applied before any clock edge
        #1;
        check_reset_state("rst");
        @(posedge clk);
        #1;
        clr = 1'b0;

        // basic latency: 0x11, 0x22, 0x33
        drive(1'b1, 1'b0, 1'b1, 32'h11); step();
        drive(1'b1, 1'b0, 1'b1, 32'h22); step();
        chk("lat_e2_q", qo[0], 32'h11);
        drive(1'b1, 1'b0, 1'b1, 32'h33); step();
        chk("lat_e3_q", qo[0], 32'h22);
        chk("lat_e3_ov", 32'(ovo[0]), 32'd1);
        chk("lat_e3_cnt", 32'(cno[0]), 32'd2);

        // stall with 0xA in stage 1 and 0xB in stage 0
        drive(1'b1, 1'b0, 1'b1, 32'hA); step();
        drive(1'b1, 1'b0, 1'b1, 32'hB); step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'hFF); step();
            chk("stall_q", qo[0], 32'hA);
            chk("stall_vv", 32'(vvo[0]), 32'h3);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0); step();
        chk("stall_release_q", qo[0], 32'hB);

        // flush with a full chain: u2 holds C1, u2f is scrubbed
        drive(1'b1, 1'b0, 1'b1, 32'hC1); step();
        drive(1'b1, 1'b0, 1'b1, 32'hC2); step();
        drive(1'b1, 1'b1, 1'b1, 32'h55); step();
        chk("flush_hold_u2", qo[0], 32'hC1);
        chk("flush_hold_u1", qo[3], 32'hC2);
        chk("flush_vv_u2", 32'(vvo[0]), 32'd0);
        chk("flush_cnt_u2", 32'(cno[0]), 32'd0);

        // bubbles into the 4-deep chain: stage 3 holds the first entry
        drive(1'b1, 1'b0, 1'b1, 32'h101); step();
        drive(1'b1, 1'b0, 1'b0, 32'h102); step();
        drive(1'b1, 1'b0, 1'b1, 32'h103); step();
        drive(1'b1, 1'b0, 1'b0, 32'h104); step();
        chk("bubble_vv_u4", 32'(vvo[2]), 32'hA);
        chk("bubble_cnt_u4", 32'(cno[2]), 32'd2);

        // async reset between edges
        drive(1'b1, 1'b0, 1'b1, 32'h1); step();
        drive(1'b1, 1'b0, 1'b1, 32'h2); step();
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("arst_q_u2f", qo[1], 32'hDEAD_BEEF);
        chk("arst_ov_u2f", 32'(ovo[1]), 32'd0);
        check_reset_state("arst");
        @(posedge clk);
        #1;
        clr = 1'b0;
        clear_models();

        // single stage: write enable behaviour
        drive(1'b1, 1'b0, 1'b1, 32'h7); step();
        chk("d1_load_q", qo[3], 32'h7);
        drive(1'b0, 1'b0, 1'b1, 32'h9); step();
        chk("d1_hold_q", qo[3], 32'h7);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 2) != 0), $urandom());
            step();
        end

        // drain every valid entry out
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0); step();
        end
        for (int k = 0; k < 4; k++)
            chk($sformatf("sb_drained%0d", k), 32'(sbq[k].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
